axis_pkt_arbiter: RTL
=====================

Name: axis_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 64-bit AXI-Stream datapath (the clk156 MAC loopback/TX path) among NUM_SRC requesters.
- A source, once granted, owns the output until its tlast beat is accepted, so packets are never interleaved.
- The output passes through a single register stage, which feeds the loopback TX input directly.

Parameters:
- NUM_SRC, 4, number of requesting AXIS sources (2..8).
- DATA_W, 64, tdata width per source.
- KEEP_W, DATA_W/8, tkeep width per source.
- SRC_W, $clog2(NUM_SRC), width of grant index.

Ports:
- clk156  in  1  156.25 MHz datapath clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i is at bits [i*DATA_W +: DATA_W].
- s_axis_tkeep  in  NUM_SRC*KEEP_W  source byte enables, packed the same way.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_W  arbitrated data.
- m_axis_tkeep  out  KEEP_W  arbitrated keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tready  in  1  downstream ready.
- grant_id  out  SRC_W  index of the current/last granted source.
- busy  out  1  high while in PASS.
- pkt_count  out  32  packets forwarded (counts m-side tlast handshakes).

Behaviour:
Reset (synchronous, reset=1 at a clk156 edge), all taking effect the next cycle:
- state=IDLE, grant_id=NUM_SRC-1 (so source 0 has first priority).
- m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, pkt_count=0, busy=0, s_axis_tready=0.
- Reset mid-packet abandons the packet. No tlast is emitted and the partial output beat is discarded. Sources must restart their packets.

FSM states: IDLE, PASS.

IDLE:
- s_axis_tready all 0.
- If any s_axis_tvalid[i]=1, pick the first i in circular order grant_id+1, grant_id+2, ... (mod NUM_SRC).
- Register grant_id=i and go to PASS next cycle. This costs exactly one arbitration bubble cycle.
- If no source is valid, stay in IDLE and hold grant_id.

PASS:
- Define adv = !m_axis_tvalid || m_axis_tready.
- s_axis_tready[grant_id] = adv. All other s_axis_tready bits are 0. This is combinational from state, grant_id, m_axis_tvalid and m_axis_tready. It must not depend on any s_axis_tvalid.
- On a source handshake (s_axis_tvalid[grant_id] && adv), load the output register with that source's tdata/tkeep/tlast and set m_axis_tvalid=1.
- If adv=1 with no source handshake, clear m_axis_tvalid.
- If adv=0, hold the output register; AXIS stability rules apply.
- When the accepted source beat has tlast=1, go to IDLE next cycle. The output beat may still be pending; IDLE keeps draining it and holds m_axis_tvalid until m_axis_tready.

Timing and throughput:
- Latency is 1 cycle from source handshake to m_axis_tvalid.
- Throughput is 1 beat per cycle within a packet.
- Each packet costs 1 extra IDLE cycle.

Arbitration rules:
- Non-granted sources never see tready=1 and are never dropped.
- A source that deasserts tvalid mid-packet keeps the grant; the arbiter waits indefinitely.
- A single-beat packet (tlast on the first beat) is handled normally.

Counters and status:
- pkt_count increments by 1 on each m_axis_tvalid && m_axis_tready && m_axis_tlast.
- pkt_count wraps from 0xFFFFFFFF to 0.
- busy = (state==PASS).

Test Plan:
1. Reset, then source 0 sends 3 beats (D0=0x1111, D1=0x2222, D2=0x3333 with tlast, tkeep=0xFF), m_tready=1 -> m_axis shows the same 3 beats in order starting 2 cycles after tvalid rises; tlast on 0x3333; pkt_count=1; grant_id=0.
2. All 4 sources hold 2-beat packets valid continuously -> packets leave in order 0,1,2,3,0 with no interleaving, 1 idle cycle between packets; pkt_count=5 after the fifth packet.
3. Source 2 granted and m_tready held 0 for 5 cycles mid-packet -> m_axis_tdata/tkeep/tlast stable, s_axis_tready[2]=0 for those cycles, no beat lost or duplicated.
4. Source 1 deasserts tvalid for 3 cycles mid-packet while source 3 is valid -> grant stays 1, s_axis_tready[3]=0 until source 1's tlast is accepted, then source 3 is granted.
5. Reset asserted in the middle of a 4-beat packet -> the next cycle shows m_axis_tvalid=0, pkt_count=0, busy=0, grant_id=NUM_SRC-1; the next packet from source 0 passes cleanly.
6. Preload pkt_count to 0xFFFFFFFF via force (or run 2^32 packets in a fast model), then send 1 single-beat packet -> pkt_count=0.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXIS arbiter: NUM_SRC sources share one registered output, no packet interleaving.
// Latency 1 cycle source-to-output plus 1 arbitration cycle per packet; only the granted source sees tready, and only while the output register can take a beat.
module axis_pkt_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                        clk156,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [SRC_W-1:0]            grant_id,
  output logic                        busy,
  output logic [31:0]                 pkt_count
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SRC_W-1:0]   grant_nxt;
  logic               adv;
  logic               src_hs;
  logic               pick_vld;
  logic [SRC_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  sel_tdata;
  logic [KEEP_W-1:0]  sel_tkeep;
  logic               sel_tvalid;
  logic               sel_tlast;

  // Output register can take a new beat when empty or being drained this cycle.
  assign adv  = !m_axis_tvalid || m_axis_tready;
  assign busy = (state == PASS);

  assign sel_tdata  = s_axis_tdata[int'(grant_id)*DATA_W +: DATA_W];
  assign sel_tkeep  = s_axis_tkeep[int'(grant_id)*KEEP_W +: KEEP_W];
  assign sel_tvalid = s_axis_tvalid[grant_id];
  assign sel_tlast  = s_axis_tlast[grant_id];
  assign src_hs     = busy && adv && sel_tvalid;

  // Circular search starting just after the last granted source.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = grant_id;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(grant_id) + k) % NUM_SRC;
      if (!pick_vld && s_axis_tvalid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = SRC_W'(idx);
      end
    end
  end

  // Ready is independent of any source valid to keep the handshake loop-free.
  always_comb begin
    s_axis_tready = '0;
    if (state == PASS) begin
      s_axis_tready[grant_id] = adv;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = PASS;
          grant_nxt = pick_idx;
        end
      end
      PASS: begin
        if (src_hs && sel_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= SRC_W'(NUM_SRC - 1);
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
    end
  end

  // In IDLE a pending beat keeps draining; nothing new is loaded.
  always_ff @(posedge clk156) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (src_hs) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_tdata;
      m_axis_tkeep  <= sel_tkeep;
      m_axis_tlast  <= sel_tlast;
    end else if (adv) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule
